// File: rtl/ghost_pkg.sv
// ghost_pkg
//   Shared definitions for the ghost movement block:
//     RIGHT/UP/DOWN/LEFT  one-hot direction codes (bit 0 = RIGHT .. bit 3 = LEFT)
//     ghost_state_t       movement FSM encoding (exposed on ghost_mover.state_dbg)
//     dir_reverse()       opposite direction of a one-hot code
//     is_onehot4()        true when exactly one of four bits is set
package ghost_pkg;

    localparam logic [3:0] RIGHT    = 4'b0001;
    localparam logic [3:0] UP       = 4'b0010;
    localparam logic [3:0] DOWN     = 4'b0100;
    localparam logic [3:0] LEFT     = 4'b1000;
    localparam logic [3:0] DIR_NONE = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DECIDE = 2'd2,
        ST_MOVE   = 2'd3
    } ghost_state_t;

    // The encoding places opposite directions at mirrored bit positions
    // (RIGHT<->LEFT, UP<->DOWN), so reversing is a bit-order swap.
    function automatic logic [3:0] dir_reverse(input logic [3:0] d);
        return {d[0], d[1], d[2], d[3]};
    endfunction

    function automatic logic is_onehot4(input logic [3:0] d);
        return (d != 4'b0000) && ((d & (d - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/ghost_dir_arbiter.sv
// ghost_dir_arbiter
//   Combinational choice of the direction for the next tile.
//   Ports:
//     move_dir       in  4  requested direction from steering (one-hot)
//     valid_moves    in  4  open directions at the current tile
//     prev_direction in  4  direction of the tile just completed
//     sel            out 4  chosen direction (0000 when nothing is open)
//     sel_ok         out 1  a direction was chosen
//   Priority: requested (if legal and not a reversal), then keep going,
//   then turn back (dead end).
module ghost_dir_arbiter
    import ghost_pkg::*;
(
    input  logic [3:0] move_dir,
    input  logic [3:0] valid_moves,
    input  logic [3:0] prev_direction,
    output logic [3:0] sel,
    output logic       sel_ok
);

    logic [3:0] rev_dir;
    logic       req_ok;
    logic       keep_ok;
    logic       back_ok;

    always_comb begin
        rev_dir = dir_reverse(prev_direction);
        req_ok  = is_onehot4(move_dir)
                  && ((move_dir & valid_moves) != 4'b0000)
                  && (move_dir != rev_dir);
        keep_ok = (prev_direction & valid_moves) != 4'b0000;
        back_ok = (rev_dir & valid_moves) != 4'b0000;

        sel = DIR_NONE;
        if (req_ok) begin
            sel = move_dir;
        end else if (keep_ok) begin
            sel = prev_direction;
        end else if (back_ok) begin
            sel = rev_dir;
        end
        sel_ok = req_ok || keep_ok || back_ok;
    end

endmodule

// File: rtl/ghost_mover.sv
// ghost_mover
//   Owns the ghost position and walks it tile by tile in the direction
//   chosen at each tile boundary.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     enable          low freezes every register (state kept, ticks ignored)
//     respawn         1-cycle pulse, back to start position and IDLE
//     step_tick       1-cycle movement strobe, only honoured in MOVE
//     move_dir        requested one-hot direction
//     valid_moves     open directions at the current position
//     ghost_pos_x/y   current position
//     prev_direction  last committed direction
//     dir_req         high on the cycle move_dir/valid_moves are sampled
//     moving          high while in MOVE
//     state_dbg       current FSM state
//   Build option: define GHOST_TUNNEL_EN to wrap x from one edge to the
//   other instead of saturating.
//   Direction handshake: dir_req is a one-cycle strobe with no ready/ack;
//   the steering logic must present move_dir and valid_moves on that same
//   cycle. SETTLE cycles after tile arrival give a clocked valid-move
//   lookup time to update before the sample.
//   SETTLE must be >= 1; TILE must be a multiple of STEP_PX.
module ghost_mover
    import ghost_pkg::*;
#(
    parameter logic [10:0] START_X = 11'd320,
    parameter logic [9:0]  START_Y = 10'd240,
    parameter int          TILE    = 16,
    parameter int          STEP_PX = 1,
    parameter int          SETTLE  = 2,
    parameter logic [10:0] X_MIN   = 11'd0,
    parameter logic [10:0] X_MAX   = 11'd639
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic         respawn,
    input  logic         step_tick,
    input  logic [3:0]   move_dir,
    input  logic [3:0]   valid_moves,
    output logic [10:0]  ghost_pos_x,
    output logic [9:0]   ghost_pos_y,
    output logic [3:0]   prev_direction,
    output logic         dir_req,
    output logic         moving,
    output ghost_state_t state_dbg
);

    localparam int STEPS_PER_TILE = TILE / STEP_PX;
    localparam int CNT_W          = $clog2(STEPS_PER_TILE + 1);
    localparam int SET_W          = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic signed [11:0] STEP12  = 12'(STEP_PX);
    localparam logic signed [11:0] XMIN12  = $signed({1'b0, X_MIN});
    localparam logic signed [11:0] XMAX12  = $signed({1'b0, X_MAX});
    localparam logic signed [11:0] YMAX12  = 12'sd479;

    ghost_state_t     state, state_nx;
    logic [CNT_W-1:0] step_cnt;
    logic [SET_W-1:0] settle_cnt;
    logic             settle_done;

    logic [3:0]          sel;
    logic                sel_ok;
    logic signed [11:0]  x_wide, y_wide;
    logic [10:0]         x_next;
    logic [9:0]          y_next;
    logic                x_clip;
    logic                tile_done;

    ghost_dir_arbiter u_arb (
        .move_dir       (move_dir),
        .valid_moves    (valid_moves),
        .prev_direction (prev_direction),
        .sel            (sel),
        .sel_ok         (sel_ok)
    );

    // Candidate position for the next step, computed one bit wider than
    // the registers so moves past either edge are visible before truncation.
    always_comb begin
        x_wide = $signed({1'b0, ghost_pos_x});
        y_wide = $signed({2'b00, ghost_pos_y});
        if (prev_direction == RIGHT) x_wide = x_wide + STEP12;
        if (prev_direction == LEFT)  x_wide = x_wide - STEP12;
        if (prev_direction == DOWN)  y_wide = y_wide + STEP12;
        if (prev_direction == UP)    y_wide = y_wide - STEP12;

        x_clip = 1'b0;
        if (x_wide < XMIN12) begin
`ifdef GHOST_TUNNEL_EN
            x_next = X_MAX;
`else
            x_next = X_MIN;
            x_clip = 1'b1;
`endif
        end else if (x_wide > XMAX12) begin
`ifdef GHOST_TUNNEL_EN
            x_next = X_MIN;
`else
            x_next = X_MAX;
            x_clip = 1'b1;
`endif
        end else begin
            x_next = x_wide[10:0];
        end

        if (y_wide < 12'sd0) begin
            y_next = 10'd0;
        end else if (y_wide > YMAX12) begin
            y_next = 10'd479;
        end else begin
            y_next = y_wide[9:0];
        end

        // A saturated x step cannot make progress, so the tile ends there.
        tile_done   = (step_cnt == CNT_W'(STEPS_PER_TILE - 1)) || x_clip;
        settle_done = (settle_cnt == SET_W'(SETTLE - 1));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        if (respawn) begin
            state_nx = ST_IDLE;
        end else if (enable) begin
            case (state)
                ST_IDLE:   state_nx = ST_SETTLE;
                ST_SETTLE: if (settle_done) state_nx = ST_DECIDE;
                ST_DECIDE: state_nx = sel_ok ? ST_MOVE : ST_SETTLE;
                ST_MOVE:   if (step_tick && tile_done) state_nx = ST_SETTLE;
                default:   state_nx = ST_IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        dir_req   = (state == ST_DECIDE) && enable && !respawn;
        moving    = (state == ST_MOVE);
        state_dbg = state;
    end

    // Position, direction and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghost_pos_x    <= START_X;
            ghost_pos_y    <= START_Y;
            prev_direction <= UP;
            step_cnt       <= '0;
            settle_cnt     <= '0;
        end else if (respawn) begin
            ghost_pos_x    <= START_X;
            ghost_pos_y    <= START_Y;
            prev_direction <= UP;
            step_cnt       <= '0;
            settle_cnt     <= '0;
        end else if (enable) begin
            case (state)
                ST_IDLE: begin
                    settle_cnt <= '0;
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_done ? '0 : settle_cnt + 1'b1;
                end
                ST_DECIDE: begin
                    settle_cnt <= '0;
                    if (sel_ok) begin
                        prev_direction <= sel;
                        step_cnt       <= '0;
                    end
                end
                ST_MOVE: begin
                    if (step_tick) begin
                        ghost_pos_x <= x_next;
                        ghost_pos_y <= y_next;
                        step_cnt    <= step_cnt + 1'b1;
                    end
                end
                default: begin
                    settle_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ghost_mover.sv
// tb_ghost_mover
//   Directed bench for ghost_mover with default parameters
//   (START 320/240, TILE 16, STEP_PX 1, SETTLE 2, x range 0..639).
//   Expectations follow GHOST_TUNNEL_EN when that macro is defined.
module tb_ghost_mover;
    import ghost_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         respawn;
    logic         step_tick;
    logic [3:0]   move_dir;
    logic [3:0]   valid_moves;
    logic [10:0]  ghost_pos_x;
    logic [9:0]   ghost_pos_y;
    logic [3:0]   prev_direction;
    logic         dir_req;
    logic         moving;
    ghost_state_t state_dbg;

    int vectors     = 0;
    int miscompares = 0;
    int n;

    ghost_mover dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .respawn        (respawn),
        .step_tick      (step_tick),
        .move_dir       (move_dir),
        .valid_moves    (valid_moves),
        .ghost_pos_x    (ghost_pos_x),
        .ghost_pos_y    (ghost_pos_y),
        .prev_direction (prev_direction),
        .dir_req        (dir_req),
        .moving         (moving),
        .state_dbg      (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock: return 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        step_tick = 1'b1;
        cyc();
        step_tick = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Cycles until dir_req is seen, bounded; -1 on timeout.
    task automatic wait_dir_req(output int cnt);
        cnt = -1;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (dir_req === 1'b1) begin
                cnt = i;
                break;
            end
        end
    endtask

    // From DECIDE: take one full tile and wait for the next DECIDE.
    task automatic run_tile();
        int c;
        cyc();
        repeat (16) tick();
        wait_dir_req(c);
        chk("tile_settle_cycles", c, 2);
    endtask

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        respawn     = 1'b0;
        step_tick   = 1'b0;
        move_dir    = RIGHT;
        valid_moves = 4'b1111;
        repeat (3) cyc();

        // Reset state
        chk("rst_x", ghost_pos_x, 320);
        chk("rst_y", ghost_pos_y, 240);
        chk("rst_prev", prev_direction, UP);
        chk("rst_dir_req", dir_req, 0);
        chk("rst_moving", moving, 0);

        // 1. first tile to the right
        rst_n  = 1'b1;
        enable = 1'b1;
        wait_dir_req(n);
        chk("t1_first_req_cycles", n, 3);
        cyc();
        chk("t1_prev_right", prev_direction, RIGHT);
        chk("t1_moving", moving, 1);
        chk("t1_dir_req_single", dir_req, 0);
        repeat (16) tick();
        chk("t1_x_after_tile", ghost_pos_x, 336);
        chk("t1_y_after_tile", ghost_pos_y, 240);
        chk("t1_settle_after_tile", moving, 0);
        wait_dir_req(n);
        chk("t1_next_req_cycles", n, 2);

        // 2. reversal request rejected, keep RIGHT; freeze while disabled
        move_dir    = LEFT;
        valid_moves = 4'b1001;
        cyc();
        chk("t2_prev_kept", prev_direction, RIGHT);
        chk("t2_moving", moving, 1);
        tick();
        chk("t2_x_step", ghost_pos_x, 337);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        chk("t2_frozen_x", ghost_pos_x, 337);
        chk("t2_frozen_moving", moving, 1);
        repeat (15) tick();
        chk("t2_x_tile_end", ghost_pos_x, 352);
        tick();  // arrives in SETTLE, dropped
        chk("t2_drop_tick_x", ghost_pos_x, 352);
        wait_dir_req(n);
        chk("t2_req_after_drop", n, 1);

        // 3. turn UP, then dead end forces DOWN
        move_dir    = UP;
        valid_moves = 4'b1111;
        cyc();
        chk("t3_prev_up", prev_direction, UP);
        repeat (16) tick();
        chk("t3_y_up", ghost_pos_y, 224);
        wait_dir_req(n);
        chk("t3_req_cycles", n, 2);
        move_dir    = DIR_NONE;
        valid_moves = 4'b0100;
        cyc();
        chk("t3_prev_dead_end", prev_direction, DOWN);
        repeat (16) tick();
        chk("t3_y_down", ghost_pos_y, 240);
        chk("t3_x_same", ghost_pos_x, 352);
        wait_dir_req(n);

        // 4. nothing open: retry every SETTLE+1 cycles, no movement
        valid_moves = 4'b0000;
        wait_dir_req(n);
        chk("t4_retry_period", n, 3);
        wait_dir_req(n);
        chk("t4_retry_period2", n, 3);
        chk("t4_prev_same", prev_direction, DOWN);
        chk("t4_x_same", ghost_pos_x, 352);
        chk("t4_y_same", ghost_pos_y, 240);
        chk("t4_not_moving", moving, 0);

        // 5. walk LEFT to X_MIN and step past it
        valid_moves = 4'b1111;
        move_dir    = LEFT;
        repeat (22) run_tile();
        chk("t5_x_at_min", ghost_pos_x, 0);
        chk("t5_prev_left", prev_direction, LEFT);
        cyc();
        tick();
`ifdef GHOST_TUNNEL_EN
        chk("t5_x_wrap", ghost_pos_x, 639);
        chk("t5_still_moving", moving, 1);
`else
        chk("t5_x_sat", ghost_pos_x, 0);
        chk("t5_tile_ended", moving, 0);
`endif

        // 6. async reset and respawn mid-MOVE
        rst_n = 1'b0;
        cyc();
        rst_n    = 1'b1;
        move_dir = RIGHT;
        wait_dir_req(n);
        chk("t6_req_cycles", n, 3);
        cyc();
        repeat (10) tick();
        chk("t6_x_330", ghost_pos_x, 330);
        chk("t6_moving", moving, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_x", ghost_pos_x, 320);
        chk("t6_async_prev", prev_direction, UP);
        chk("t6_async_moving", moving, 0);
        chk("t6_async_state", state_dbg, ST_IDLE);
        cyc();
        rst_n = 1'b1;
        wait_dir_req(n);
        chk("t6_req_cycles2", n, 3);
        cyc();
        repeat (5) tick();
        chk("t6_x_325", ghost_pos_x, 325);
        respawn   = 1'b1;
        step_tick = 1'b1;
        cyc();
        respawn   = 1'b0;
        step_tick = 1'b0;
        chk("t6_respawn_x", ghost_pos_x, 320);
        chk("t6_respawn_y", ghost_pos_y, 240);
        chk("t6_respawn_prev", prev_direction, UP);
        chk("t6_respawn_state", state_dbg, ST_IDLE);
        chk("t6_respawn_moving", moving, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
